// File: rtl/uart_rx_fifo_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_pkg
//   Constants and helpers shared by the UART receive buffer and its idle
//   timer.
//   UART_FRAME_BITS : line bits per character (start + 8 data + stop).
//   idle_cycles()   : clocks spanning a number of character times, used as
//                     the default idle threshold.
// ---------------------------------------------------------------------------
package uart_rx_fifo_pkg;

    localparam int UART_FRAME_BITS = 10;

    // Clocks covering idle_chars whole characters at the given baud rate.
    // The integer division truncates, so a slightly short bit time is used.
    function automatic int idle_cycles(input int clk_hz, input int baud,
                                       input int idle_chars);
        return idle_chars * UART_FRAME_BITS * (clk_hz / baud);
    endfunction

endpackage

// File: rtl/uart_idle_timer.sv
// ---------------------------------------------------------------------------
// uart_idle_timer
//   Reports that the line has gone quiet after traffic. Any event arms the
//   timer and reloads the countdown. idle_strobe pulses for one cycle exactly
//   IDLE_CYCLES cycles after the last event. The timer then disarms until
//   the next event arrives.
//   Ports:
//     clk         in  system clock
//     nrst        in  synchronous active-low reset
//     event_in    in  rx_done or rx_err strobe from the receiver
//     idle_strobe out one-cycle pulse on reaching the idle threshold
// ---------------------------------------------------------------------------
module uart_idle_timer #(
    parameter int IDLE_CYCLES = 20
) (
    input  logic clk,
    input  logic nrst,
    input  logic event_in,
    output logic idle_strobe
);

    localparam int CW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(IDLE_CYCLES - 1);

    logic          armed;
    logic [CW-1:0] cnt;

    // NOTE: state registers use non-blocking assignments. Every flop then
    // samples the values from before the edge, whatever the block order.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            armed <= 1'b0;
            cnt   <= '0;
        end else if (event_in) begin
            armed <= 1'b1;
            cnt   <= RELOAD;
        end else if (armed) begin
            if (cnt == '0) begin
                armed <= 1'b0;
            end else begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    // The pulse decodes straight from flops and lasts one cycle, because
    // the zero count disarms the timer on the following edge. A new event
    // in the strobe cycle rearms the timer without suppressing the pulse.
    assign idle_strobe = armed && (cnt == '0);

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//   Buffers the bytes of a UART receiver in a circular FIFO. The FIFO has a
//   first-word-fall-through valid/ready read side. The block also keeps
//   overflow and framing-error statistics and flags the end of a packet
//   when the line goes idle.
//   Ports:
//     clk           in  system clock
//     nrst          in  synchronous active-low reset
//     rx_data[7:0]  in  received byte, qualified by rx_done
//     rx_done       in  strobe: rx_data is a good byte
//     rx_err        in  strobe: framing error
//     out_data[7:0] out head-of-FIFO byte, meaningful while out_valid=1
//     out_valid     out FIFO non-empty
//     out_ready     in  consumer takes out_data this cycle
//     fill          out occupancy 0..DEPTH
//     full          out fill == DEPTH
//     overflow      out sticky: a good byte was dropped while full
//     frame_err_cnt out saturating count of rx_err strobes
//     idle_strobe   out one-cycle pulse when the line goes quiet
//     clr_stat      in  clears overflow and frame_err_cnt
// ---------------------------------------------------------------------------
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int CLK_HZ      = 200_000_000,
    parameter int BAUD        = 9600,
    parameter int IDLE_CHARS  = 3,
    parameter int IDLE_CYCLES = idle_cycles(CLK_HZ, BAUD, IDLE_CHARS)
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic [7:0]               rx_data,
    input  logic                     rx_done,
    input  logic                     rx_err,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     full,
    output logic                     overflow,
    output logic [7:0]               frame_err_cnt,
    output logic                     idle_strobe,
    input  logic                     clr_stat
);

    localparam int PW = $clog2(DEPTH);
    localparam int FW = PW + 1;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic push_req;
    logic push_ok;
    logic pop;

    // A framing error overrides a simultaneous rx_done, so the byte is never
    // stored.
    assign push_req = rx_done && !rx_err;
    assign pop      = out_valid && out_ready;
    // A full FIFO always has out_valid set. A pop in the same cycle frees
    // the slot the push needs.
    assign push_ok  = push_req && (!full || pop);

    assign out_valid = (fill != '0);
    assign full      = (fill == FW'(DEPTH));
    assign out_data  = mem[rd_ptr];

    // NOTE: the storage array has no reset. Stale entries are never visible
    // because out_valid masks them. A reset here would turn the RAM into
    // DEPTH*8 resettable flops.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    // Pointers wrap naturally at DEPTH, a power of two. Occupancy is kept in
    // the wider fill counter.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   fill <= fill + FW'(1);
                2'b01:   fill <= fill - FW'(1);
                default: fill <= fill;
            endcase
        end
    end

    // Statistics. clr_stat takes priority over events in the same cycle.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            overflow      <= 1'b0;
            frame_err_cnt <= '0;
        end else if (clr_stat) begin
            overflow      <= 1'b0;
            frame_err_cnt <= '0;
        end else begin
            if (push_req && full && !pop) begin
                overflow <= 1'b1;
            end
            if (rx_err && (frame_err_cnt != 8'hFF)) begin
                frame_err_cnt <= frame_err_cnt + 8'd1;
            end
        end
    end

    uart_idle_timer #(
        .IDLE_CYCLES (IDLE_CYCLES)
    ) u_idle_timer (
        .clk         (clk),
        .nrst        (nrst),
        .event_in    (rx_done || rx_err),
        .idle_strobe (idle_strobe)
    );

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Downstream stage of the UART receiver. Consumes its per-byte strobes: rx_data, rx_done, rx_err.
- Buffers good bytes in a circular FIFO and presents them on a first-word-fall-through valid/ready interface.
- Keeps overflow and framing-error statistics.
- Raises a one-cycle idle strobe when the line has gone quiet after traffic, so consumers can detect end-of-packet.

Parameters:
- DEPTH, 16: FIFO entries; must be a power of 2, minimum 2.
- CLK_HZ, 200000000: clock frequency in Hz.
- BAUD, 9600: line baud rate.
- IDLE_CHARS, 3: character times (10 bits each) without rx_done before idle_strobe fires.
- IDLE_CYCLES, IDLE_CHARS*10*(CLK_HZ/BAUD): derived idle threshold in clocks; may be overridden directly for simulation.

Ports:
- clk  in  1  system clock.
- nrst  in  1  synchronous active-low reset.
- rx_data  in  8  received byte; qualified by rx_done.
- rx_done  in  1  one-cycle strobe: rx_data holds a good byte.
- rx_err  in  1  one-cycle strobe: framing error (stop bit low).
- out_data  out  8  head-of-FIFO byte; valid when out_valid=1.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts out_data this cycle.
- fill  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  out  1  fill==DEPTH.
- overflow  out  1  sticky: a good byte was dropped because the FIFO was full.
- frame_err_cnt  out  8  saturating count of rx_err strobes.
- idle_strobe  out  1  one-cycle pulse when the line goes idle after at least one byte.
- clr_stat  in  1  clears overflow and frame_err_cnt.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on nrst; it is sampled only on the posedge of clk.
- Reset values: fill=0, out_valid=0, full=0, overflow=0, frame_err_cnt=0, idle_strobe=0, read/write pointers=0, idle counter disarmed. FIFO storage contents are not reset; out_data is don't-care while out_valid=0.
- Pointer width: pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH. Occupancy is tracked in a separate fill counter, one bit wider than the pointers.
- Write: on rx_done=1 with the FIFO not full, write mem[wr_ptr]<=rx_data and increment wr_ptr.
- Write latency: a byte strobed at edge N shows out_valid=1 and the byte on out_data after edge N. Latency is 1 cycle.
- Read: a pop occurs when out_valid and out_ready are both 1; rd_ptr increments. out_data is mem[rd_ptr], combinational from the storage array (FWFT).
- Simultaneous push and pop: fill is unchanged.
- Push when full without a pop: the byte is discarded and overflow<=1.
- Push when full with a pop in the same cycle: the push is accepted, fill stays DEPTH, overflow is not set.
- Pop when empty: impossible, because out_valid=0. out_ready is ignored.
- rx_err: writes nothing. frame_err_cnt increments, saturating at 255.
- rx_done and rx_err together (illegal upstream): rx_err wins and no write occurs.
- clr_stat: overflow<=0 and frame_err_cnt<=0 on the next edge.
- clr_stat in the same cycle as a new overflow or rx_err event: the clear wins.
- clr_stat does not affect FIFO contents.
- Idle detector, arm/restart: any rx_done or rx_err arms the detector and reloads the counter with IDLE_CYCLES-1.
- Idle detector, count: while armed and with no strobe, the counter decrements each cycle.
- Idle detector, fire: when the counter reaches 0, idle_strobe=1 for exactly one cycle, then the detector disarms.
- Idle detector, restart: a new strobe arriving during the countdown reloads the counter.
- Idle detector, no repeat: idle_strobe does not repeat until the next strobe. It fires regardless of FIFO occupancy.
- Reset mid-operation: all state returns to the reset values on the next edge. Buffered bytes are lost.

Decomposition:
- Shared package holds:
  - UART_FRAME_BITS=10.
  - A function computing the idle cycles from CLK_HZ, BAUD and IDLE_CHARS.
  - A clog2 helper, if the codebase has none.
- One sub-module is natural: uart_idle_timer, containing the arm/reload/countdown/strobe logic with parameter IDLE_CYCLES.
- The FIFO core stays inline.

Test Plan:
- Write path, DEPTH=4: after reset, pulse rx_done with 0x55 and out_ready=0 -> next cycle out_valid=1, out_data=0x55, fill=1.
- Order: push 0x01,0x02,0x03,0x04 -> full=1, fill=4. Push 0x05 -> overflow=1, fill=4. Pop four with out_ready=1 -> bytes 0x01..0x04 in order, then out_valid=0.
- Full boundary: with the FIFO full, push 0xAA while popping -> overflow stays 0, fill=4, and 0xAA is the last byte read out. Run 10 push/pop rounds to check pointer wrap.
- Framing errors: 300 rx_err pulses -> frame_err_cnt saturates at 255 and the FIFO stays empty. Assert clr_stat with one more rx_err in the same cycle -> frame_err_cnt=0.
- Idle detector, IDLE_CYCLES=20: rx_done at cycle 0 -> idle_strobe high only at cycle 20. A second rx_done at cycle 10 moves the strobe to cycle 30. No further strobe without new traffic.
- Reset: with fill=3, drive nrst=0 for one edge -> fill=0, out_valid=0, overflow=0, idle_strobe never fires afterwards.
